// File: rtl/dlfloat_mult_pipe.sv
// Pipelined DLFloat multiplier with valid/ready flow control, selectable rounding and flags.
// Optional sticky status flags are enabled with the DLF_MULT_STICKY_FLAGS_EN macro.
module dlfloat_mult_pipe #(
    parameter int unsigned EXP_W       = 6,
    parameter int unsigned MAN_W       = 9,
    parameter int unsigned BIAS        = 31,
    parameter int unsigned PIPE_STAGES = 3,
    parameter bit          ROUND_RNE   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
`ifdef DLF_MULT_STICKY_FLAGS_EN
    output logic [3:0]               out_flags,
    input  logic                     status_clr,
    output logic [3:0]               status_flags
`else
    output logic [3:0]               out_flags
`endif
);

    localparam int unsigned W   = 1 + EXP_W + MAN_W;
    localparam int unsigned SW  = MAN_W + 1;
    localparam int unsigned PW  = 2 * SW;
    localparam int unsigned EW  = EXP_W + 2;
    localparam int unsigned S1W = 3 + EW + 2 * SW;
    localparam int unsigned S2W = 3 + EW + PW;
    localparam int unsigned S3W = W + 4;
    localparam logic signed [EW-1:0] EMax = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EMin = EW'(1);

    // The whole pipeline stalls together whenever the output is held.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage 1: unpack, classify, sign and biased exponent sum
    logic [EXP_W-1:0]     ea, eb;
    logic                 s1c_sign, s1c_nan, s1c_zero;
    logic signed [EW-1:0] s1c_e;
    logic [SW-1:0]        s1c_ma, s1c_mb;
    logic [S1W-1:0]       s1c_pl, s1_pl;
    logic                 s1_valid;

    always_comb begin
        ea       = in_a[MAN_W +: EXP_W];
        eb       = in_b[MAN_W +: EXP_W];
        s1c_sign = in_a[W-1] ^ in_b[W-1];
        s1c_nan  = (&in_a[W-2:0]) || (&in_b[W-2:0]);
        s1c_zero = (ea == '0) || (eb == '0);
        s1c_e    = EW'(ea) + EW'(eb) - EW'(BIAS);
        s1c_ma   = {1'b1, in_a[MAN_W-1:0]};
        s1c_mb   = {1'b1, in_b[MAN_W-1:0]};
    end

    assign s1c_pl = {s1c_sign, s1c_nan, s1c_zero, s1c_e, s1c_ma, s1c_mb};

    if (PIPE_STAGES >= 2) begin : g_s1_reg
        logic           s1_valid_d, s1_valid_q;
        logic [S1W-1:0] s1_pl_d, s1_pl_q;

        always_comb begin
            s1_valid_d = s1_valid_q;
            s1_pl_d    = s1_pl_q;
            if (advance) begin
                s1_valid_d = in_valid;
                s1_pl_d    = s1c_pl;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid_q <= 1'b0;
                s1_pl_q    <= '0;
            end else begin
                s1_valid_q <= s1_valid_d;
                s1_pl_q    <= s1_pl_d;
            end
        end

        assign s1_valid = s1_valid_q;
        assign s1_pl    = s1_pl_q;
    end else begin : g_s1_bypass
        assign s1_valid = in_valid;
        assign s1_pl    = s1c_pl;
    end

    // Stage 2: significand product
    logic                 u1_sign, u1_nan, u1_zero;
    logic signed [EW-1:0] u1_e;
    logic [SW-1:0]        u1_ma, u1_mb;
    logic [PW-1:0]        s2c_prod;
    logic [S2W-1:0]       s2c_pl, s2_pl;
    logic                 s2_valid;

    assign {u1_sign, u1_nan, u1_zero, u1_e, u1_ma, u1_mb} = s1_pl;
    assign s2c_prod = PW'(u1_ma) * PW'(u1_mb);
    assign s2c_pl   = {u1_sign, u1_nan, u1_zero, u1_e, s2c_prod};

    if (PIPE_STAGES >= 3) begin : g_s2_reg
        logic           s2_valid_d, s2_valid_q;
        logic [S2W-1:0] s2_pl_d, s2_pl_q;

        always_comb begin
            s2_valid_d = s2_valid_q;
            s2_pl_d    = s2_pl_q;
            if (advance) begin
                s2_valid_d = s1_valid;
                s2_pl_d    = s2c_pl;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid_q <= 1'b0;
                s2_pl_q    <= '0;
            end else begin
                s2_valid_q <= s2_valid_d;
                s2_pl_q    <= s2_pl_d;
            end
        end

        assign s2_valid = s2_valid_q;
        assign s2_pl    = s2_pl_q;
    end else begin : g_s2_bypass
        assign s2_valid = s1_valid;
        assign s2_pl    = s2c_pl;
    end

    // Stage 3: normalise, round, range check, pack
    logic                 u2_sign, u2_nan, u2_zero;
    logic signed [EW-1:0] u2_e;
    logic [PW-1:0]        u2_prod;
    logic                 msb, guard, sticky, round_up, inexact;
    logic [PW-2:0]        norm;
    logic [MAN_W-1:0]     frac, frac_fin;
    logic [SW-1:0]        rnd;
    logic signed [EW-1:0] e_fin;
    logic [W-1:0]         s3c_res;
    logic [3:0]           s3c_flags;
    logic [S3W-1:0]       s3_pl;
    logic                 s3_valid;

    assign {u2_sign, u2_nan, u2_zero, u2_e, u2_prod} = s2_pl;

    always_comb begin
        msb       = u2_prod[PW-1];
        // Hidden bit dropped; norm holds the fraction followed by the discarded bits.
        norm      = msb ? u2_prod[PW-2:0] : {u2_prod[PW-3:0], 1'b0};
        frac      = norm[PW-2 -: MAN_W];
        guard     = norm[PW-2-MAN_W];
        sticky    = |norm[PW-3-MAN_W:0];
        inexact   = guard || sticky;
        round_up  = ROUND_RNE && guard && (sticky || frac[0]);
        rnd       = {1'b0, frac} + SW'(round_up);
        frac_fin  = rnd[MAN_W-1:0];
        e_fin     = u2_e + EW'(msb) + EW'(rnd[MAN_W]);
        s3c_res   = '0;
        s3c_flags = 4'b0000;
        if (u2_nan) begin
            s3c_res   = {u2_sign, {(W-1){1'b1}}};
            s3c_flags = 4'b1000;
        end else if (!u2_zero) begin
            if (e_fin > EMax || (e_fin == EMax && (&frac_fin))) begin
                s3c_res   = {u2_sign, {(W-1){1'b1}}};
                s3c_flags = 4'b0100;
            end else if (e_fin < EMin) begin
                s3c_flags = 4'b0011;
            end else begin
                s3c_res   = {u2_sign, e_fin[EXP_W-1:0], frac_fin};
                s3c_flags = {3'b000, inexact};
            end
        end
    end

    if (PIPE_STAGES >= 4) begin : g_s3_reg
        logic           s3_valid_d, s3_valid_q;
        logic [S3W-1:0] s3_pl_d, s3_pl_q;

        always_comb begin
            s3_valid_d = s3_valid_q;
            s3_pl_d    = s3_pl_q;
            if (advance) begin
                s3_valid_d = s2_valid;
                s3_pl_d    = {s3c_res, s3c_flags};
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s3_valid_q <= 1'b0;
                s3_pl_q    <= '0;
            end else begin
                s3_valid_q <= s3_valid_d;
                s3_pl_q    <= s3_pl_d;
            end
        end

        assign s3_valid = s3_valid_q;
        assign s3_pl    = s3_pl_q;
    end else begin : g_s3_bypass
        assign s3_valid = s2_valid;
        assign s3_pl    = {s3c_res, s3c_flags};
    end

    // Output register
    logic         out_valid_d, out_valid_q;
    logic [W-1:0] out_result_d, out_result_q;
    logic [3:0]   out_flags_d, out_flags_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        if (advance) begin
            out_valid_d                 = s3_valid;
            {out_result_d, out_flags_d} = s3_pl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= 4'b0000;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

`ifdef DLF_MULT_STICKY_FLAGS_EN
    logic [3:0] status_flags_d, status_flags_q;

    // Clear first so a same-cycle handshake still records its flags.
    always_comb begin
        status_flags_d = status_clr ? 4'b0000 : status_flags_q;
        if (out_valid && out_ready) begin
            status_flags_d = status_flags_d | out_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_flags_q <= 4'b0000;
        end else begin
            status_flags_q <= status_flags_d;
        end
    end

    assign status_flags = status_flags_q;
`endif

endmodule
